// File: rtl/pico_bus_fabric.sv
// PicoRV32 native-bus interconnect: one CPU master, N_SLV base/mask-decoded slaves,
// registered slave requests, decode/timeout error responses and a status/IRQ register.
module pico_bus_fabric #(
    parameter int unsigned          N_SLV     = 4,
    parameter logic [N_SLV*32-1:0]  SLV_BASE  = {32'h0000_8030, 32'h0000_8020, 32'h0000_8000, 32'h0000_0000},
    parameter logic [N_SLV*32-1:0]  SLV_MASK  = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_8000},
    parameter int unsigned          TIMEOUT   = 255,
    parameter logic [31:0]          ERR_DATA  = 32'hDEAD_BEEF,
    parameter logic [31:0]          STAT_ADDR = 32'h0000_9000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_valid,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_wstrb,
    output logic                 m_ready,
    output logic [31:0]          m_rdata,
    output logic [N_SLV-1:0]     s_valid,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    input  logic [N_SLV-1:0]     s_ready,
    input  logic [N_SLV*32-1:0]  s_rdata,
    output logic                 bus_err_irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t             state_q;
    logic [N_SLV-1:0]   sel_q;
    logic [2:0]         idx_q;
    logic [15:0]        cnt_q;
    logic [31:0]        stat_q;
    logic               m_ready_q;
    logic [31:0]        m_rdata_q;
    logic [N_SLV-1:0]   s_valid_q;
    logic [31:0]        s_addr_q;
    logic [31:0]        s_wdata_q;
    logic [3:0]         s_wstrb_q;

    logic               is_stat;
    logic               hit_any;
    logic [2:0]         hit_idx;
    logic [N_SLV-1:0]   hit_oh;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    // Status word for a new error: sticky flag, cause, faulting slave, saturating count.
    function automatic logic [31:0] rec_err(input logic [31:0] st,
                                            input logic        tmo,
                                            input logic [2:0]  idx);
        logic [15:0] cnt;
        cnt = (st[31:16] == 16'hFFFF) ? st[31:16] : st[31:16] + 16'd1;
        return {cnt, 5'd0, idx, 6'd0, tmo, 1'b1};
    endfunction

    always_comb begin
        is_stat = (m_addr == STAT_ADDR);
        hit_any = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        // Ascending scan with a found flag gives lowest-index priority on overlap.
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!hit_any && ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit_any   = 1'b1;
                hit_idx   = 3'(i);
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            stat_q    <= '0;
            m_ready_q <= 1'b0;
            m_rdata_q <= '0;
            s_valid_q <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    m_ready_q <= 1'b0;
                    if (m_valid) begin
                        s_addr_q  <= m_addr;
                        s_wdata_q <= m_wdata;
                        s_wstrb_q <= m_wstrb;
                        if (is_stat) begin
                            m_rdata_q <= stat_q;
                            if (|m_wstrb) begin
                                stat_q <= '0;
                            end
                            m_ready_q <= 1'b1;
                            state_q   <= RESP;
                        end else if (hit_any) begin
                            sel_q     <= hit_oh;
                            idx_q     <= hit_idx;
                            s_valid_q <= hit_oh;
                            cnt_q     <= '0;
                            state_q   <= ACCESS;
                        end else begin
                            m_rdata_q <= ERR_DATA;
                            stat_q    <= rec_err(stat_q, 1'b0, 3'd0);
                            m_ready_q <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        m_rdata_q <= sel_rdata;
                        s_valid_q <= '0;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        m_rdata_q <= ERR_DATA;
                        s_valid_q <= '0;
                        stat_q    <= rec_err(stat_q, 1'b1, idx_q);
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    m_ready_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    m_ready_q <= 1'b0;
                    s_valid_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign m_ready     = m_ready_q;
    assign m_rdata     = m_rdata_q;
    assign s_valid     = s_valid_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign bus_err_irq = stat_q[0];

endmodule

// File: tb/tb_pico_bus_fabric.sv
// Self-checking bench for pico_bus_fabric: scoreboard of expected read data plus
// per-scenario latency, decode, timeout, status and reset checks.
module tb_pico_bus_fabric;

    localparam logic [31:0] STAT = 32'h0000_9000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          m_valid;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_ready;
    logic [31:0]   m_rdata;
    logic [3:0]    s_valid;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [3:0]    s_ready;
    logic [127:0]  s_rdata;
    logic          bus_err_irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    int          lat;
    int          sv_first;
    int          sv_cycles;
    logic [3:0]  sv_seen;
    logic [3:0]  sv_at_resp;
    logic [31:0] obs_rdata;
    logic [31:0] obs_saddr;
    logic [31:0] obs_swdata;
    logic [3:0]  obs_swstrb;

    always #5 clk = ~clk;

    pico_bus_fabric #(
        .N_SLV   (4),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .bus_err_irq (bus_err_irq)
    );

    // Cycle 0 is the cycle m_valid is raised; the selected slave raises s_ready
    // `waits` cycles after its first s_valid cycle. Other slaves drive `noise`.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int slv, input int waits,
                              input logic [3:0] noise, input logic [31:0] rd);
        @(posedge clk); #1;
        s_rdata = {4{~rd}};
        if (slv >= 0) s_rdata[32*slv +: 32] = rd;
        s_ready = noise;
        if (slv >= 0) s_ready[slv] = 1'b0;
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
        lat = -1; sv_first = -1; sv_cycles = 0; sv_seen = '0; sv_at_resp = '0;
        obs_rdata = '0; obs_saddr = '0; obs_swdata = '0; obs_swstrb = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (m_ready) begin
                lat = c; obs_rdata = m_rdata; sv_at_resp = s_valid;
                break;
            end
            if (s_valid != '0) begin
                sv_cycles++;
                sv_seen |= s_valid;
                if (sv_first < 0) begin
                    sv_first = c; obs_saddr = s_addr; obs_swdata = s_wdata; obs_swstrb = s_wstrb;
                end
            end
            if (slv >= 0) s_ready[slv] = (sv_first >= 0 && s_valid[slv] && (c - sv_first) >= waits);
        end
        m_valid = 1'b0; m_wstrb = '0; s_ready = '0;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL reset_m_ready got %b exp 0", m_ready); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL reset_m_rdata got %h exp 0", m_rdata); end
        checks++; if (s_valid !== 4'h0) begin failures++; $display("FAIL reset_s_valid got %b exp 0000", s_valid); end
        checks++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin failures++; $display("FAIL reset_s_bus got %h %h %h exp 0", s_addr, s_wdata, s_wstrb); end
        checks++; if (bus_err_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", bus_err_irq); end
        exp_q.push_back(32'h0);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL reset_status got %h exp %h", obs_rdata, e); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL reset_status_lat got %0d exp 1", lat); end
    endtask

    task automatic test_read_slave0;
        logic [31:0] e;
        exp_q.push_back(32'h1234_5678);
        run_access(32'h0000_0040, 32'h0, 4'h0, 0, 0, 4'h0, 32'h1234_5678);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL rd0_data got %h exp %h", obs_rdata, e); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd0_lat got %0d exp 2", lat); end
        checks++; if (sv_first !== 1 || sv_seen !== 4'b0001) begin failures++; $display("FAIL rd0_svalid got first=%0d sel=%b exp first=1 sel=0001", sv_first, sv_seen); end
    endtask

    task automatic test_write_slave2;
        logic [31:0] e;
        run_access(32'h0000_8024, 32'hCAFE_F00D, 4'b0011, 2, 3, 4'h0, 32'h0);
        checks++; if (lat !== 5) begin failures++; $display("FAIL wr2_lat got %0d exp 5", lat); end
        checks++; if (sv_seen !== 4'b0100) begin failures++; $display("FAIL wr2_sel got %b exp 0100", sv_seen); end
        checks++; if (obs_saddr !== 32'h0000_8024 || obs_swstrb !== 4'b0011 || obs_swdata !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL wr2_sbus got %h %b %h exp 00008024 0011 cafef00d", obs_saddr, obs_swstrb, obs_swdata); end
        exp_q.push_back(32'h0);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL wr2_status got %h exp %h", obs_rdata, e); end
    endtask

    task automatic test_unmapped;
        logic [31:0] e;
        exp_q.push_back(ERRD);
        run_access(32'h0001_0000, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL unm_data got %h exp %h", obs_rdata, e); end
        checks++; if (lat !== 1 || sv_seen !== 4'h0) begin failures++; $display("FAIL unm_lat got lat=%0d sel=%b exp lat=1 sel=0000", lat, sv_seen); end
        checks++; if (bus_err_irq !== 1'b1) begin failures++; $display("FAIL unm_irq got %b exp 1", bus_err_irq); end
        exp_q.push_back(32'h0001_0001);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL unm_status got %h exp %h", obs_rdata, e); end
    endtask

    task automatic test_timeout;
        logic [31:0] e;
        exp_q.push_back(ERRD);
        run_access(32'h0000_8000, 32'h0, 4'h0, 1, 1000, 4'b1101, 32'h5555_AAAA);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL tmo_data got %h exp %h", obs_rdata, e); end
        checks++; if (sv_cycles !== 8 || sv_seen !== 4'b0010 || sv_at_resp !== 4'h0) begin
            failures++; $display("FAIL tmo_svalid got cycles=%0d sel=%b resp=%b exp 8 0010 0000", sv_cycles, sv_seen, sv_at_resp); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL tmo_lat got %0d exp 9", lat); end
        exp_q.push_back(32'h0002_0103);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL tmo_status got %h exp %h", obs_rdata, e); end
        run_access(STAT, 32'h0, 4'b0001, -1, 0, 4'h0, 32'h0);
        checks++; if (bus_err_irq !== 1'b0) begin failures++; $display("FAIL clr_irq got %b exp 0", bus_err_irq); end
        exp_q.push_back(32'h0);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL clr_status got %h exp %h", obs_rdata, e); end
    endtask

    task automatic test_ready_on_timeout;
        logic [31:0] e;
        exp_q.push_back(32'h0BAD_F00D);
        run_access(32'h0000_8030, 32'h0, 4'h0, 3, 7, 4'h0, 32'h0BAD_F00D);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL edge_data got %h exp %h", obs_rdata, e); end
        checks++; if (lat !== 9 || sv_cycles !== 8) begin failures++; $display("FAIL edge_lat got lat=%0d cycles=%0d exp 9 8", lat, sv_cycles); end
        checks++; if (bus_err_irq !== 1'b0) begin failures++; $display("FAIL edge_irq got %b exp 0", bus_err_irq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        exp_q.push_back(32'hA5A5_0001);
        exp_q.push_back(32'h5A5A_0003);
        run_access(32'h0000_0100, 32'h0, 4'h0, 0, 0, 4'h0, 32'hA5A5_0001);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e || lat !== 2) begin failures++; $display("FAIL b2b_first got %h lat=%0d exp %h lat=2", obs_rdata, lat, e); end
        run_access(32'h0000_803C, 32'h0, 4'h0, 3, 1, 4'h0, 32'h5A5A_0003);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e || lat !== 3) begin failures++; $display("FAIL b2b_second got %h lat=%0d exp %h lat=3", obs_rdata, lat, e); end
    endtask

    task automatic test_reset_mid_access;
        int rdy_seen;
        @(posedge clk); #1;
        s_ready = '0; m_valid = 1'b1; m_addr = 32'h0000_0040; m_wstrb = '0;
        @(posedge clk); #1;
        checks++; if (s_valid !== 4'b0001) begin failures++; $display("FAIL rstmid_sel got %b exp 0001", s_valid); end
        @(posedge clk); #1;
        reset = 1'b1; m_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_valid !== 4'h0 || m_ready !== 1'b0) begin failures++; $display("FAIL rstmid_abort got sv=%b rdy=%b exp 0000 0", s_valid, m_ready); end
        reset = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (m_ready) rdy_seen++;
        end
        checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL rstmid_noready got %0d exp 0", rdy_seen); end
    endtask

    // Preload the error count just below saturation rather than issuing 65536 accesses.
    task automatic test_saturate;
        logic [31:0] e;
        @(negedge clk);
        force dut.stat_q = 32'hFFFD_0001;
        @(negedge clk);
        release dut.stat_q;
        run_access(32'h0002_0000, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        exp_q.push_back(32'hFFFE_0001);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL sat_step got %h exp %h", obs_rdata, e); end
        for (int k = 0; k < 3; k++) run_access(32'hF000_0000, 32'h1, 4'hF, -1, 0, 4'h0, 32'h0);
        exp_q.push_back(32'hFFFF_0001);
        run_access(STAT, 32'h0, 4'h0, -1, 0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++; if (obs_rdata !== e) begin failures++; $display("FAIL sat_hold got %h exp %h", obs_rdata, e); end
    endtask

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_read_slave0();
        test_write_slave2();
        test_unmapped();
        test_timeout();
        test_ready_on_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_read_slave0();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
